muldiv_unit: RTL and testbench

Parametrised multiply/divide unit for the E stage of the pipelined CPU. It executes mult/multu/div/divu with configurable latency, holds HI/LO, and services mthi/mtlo and mfhi/mflo. It reports `E_Start`/`E_Busy` so hazard logic can stall MD instructions in D. It consumes the `MDControl`/`MDDataOp` encoding produced by the main decoder.

---
 rtl/muldiv_unit.sv | 69 ++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div unit holding HI/LO, with mt/mf access and busy/start handshakes.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       E_MDControl,
  input  logic             E_MDDataOp,
  input  logic             E_Valid,
  input  logic [WIDTH-1:0] E_A,
  input  logic [WIDTH-1:0] E_B,
  output logic             E_Start,
  output logic             E_Busy,
  output logic [WIDTH-1:0] E_MDOut
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo, res_hi, res_lo, ub, uq, ur;
  logic signed [WIDTH-1:0] sb, sq, sr;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0] cnt;
  logic is_mul, is_div, div0, ovf;
  always_comb begin
    is_mul = E_MDControl == 4'd1 || E_MDControl == 4'd2;
    is_div = E_MDControl == 4'd3 || E_MDControl == 4'd4;
    div0   = E_B == '0;
    ovf    = E_MDControl == 4'd3 && E_A == MIN_VAL && E_B == '1;
    prod   = E_MDControl == 4'd1 ? {{WIDTH{E_A[WIDTH-1]}}, E_A} * {{WIDTH{E_B[WIDTH-1]}}, E_B}
                                 : {{WIDTH{1'b0}}, E_A} * {{WIDTH{1'b0}}, E_B};
    // Divisor forced to 1 for /0 and MIN/-1: keeps the divider defined and gives LO=MIN, HI=0 on overflow
    sb     = (div0 || ovf) ? WIDTH'(1) : $signed(E_B);
    sq     = $signed(E_A) / sb;
    sr     = $signed(E_A) % sb;
    ub     = div0 ? WIDTH'(1) : E_B;
    uq     = E_A / ub;
    ur     = E_A % ub;
    // HI/LO cannot change while busy, so a /0 result simply recommits the current values
    res_hi = (is_div && div0) ? hi : E_MDControl == 4'd3 ? sr : E_MDControl == 4'd4 ? ur : prod[2*WIDTH-1:WIDTH];
    res_lo = (is_div && div0) ? lo : E_MDControl == 4'd3 ? sq : E_MDControl == 4'd4 ? uq : prod[WIDTH-1:0];
  end
  assign E_Busy  = cnt != '0;
  assign E_Start = reset & E_Valid & ~E_Busy & (is_mul | is_div);
  assign E_MDOut = E_MDDataOp ? hi : lo;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
    end else if (E_Start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (E_Busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (E_Valid) begin
      if (E_MDControl == 4'd5) lo <= E_A;
      if (E_MDControl == 4'd6) hi <= E_A;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit at two latency configurations.
module tb_muldiv_unit;
  logic clk = 0, rst_n = 1, sel = 0, dsel = 0, valid = 0;
  logic [3:0] ctl = 0;
  logic [31:0] va = 0, vb = 0;
  logic a_start, a_busy, b_start, b_busy;
  logic [31:0] a_out, b_out;
  logic [31:0] rd_q[$];
  bit st_q[$];
  int len_q[$];
  int errors = 0, checks = 0, cyc = 0, free_at = 0, run = 0;
  logic [31:0] o_hi = 0, o_lo = 0, n_hi = 0, n_lo = 0;
  logic m_busy, m_start;
  logic [31:0] m_out;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut_a (
    .clk(clk), .reset(rst_n), .E_MDControl(ctl), .E_MDDataOp(dsel), .E_Valid(valid & ~sel),
    .E_A(va), .E_B(vb), .E_Start(a_start), .E_Busy(a_busy), .E_MDOut(a_out));
  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_n), .E_MDControl(ctl), .E_MDDataOp(dsel), .E_Valid(valid & sel),
    .E_A(va), .E_B(vb), .E_Start(b_start), .E_Busy(b_busy), .E_MDOut(b_out));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the selected DUT presents a read, a start decision or a busy run
  always @(negedge clk) begin
    m_busy  = sel ? b_busy : a_busy;
    m_start = sel ? b_start : a_start;
    m_out   = sel ? b_out : a_out;
    if (!rst_n) begin
      chk("busy_in_reset", {31'b0, m_busy}, 32'd0);
      run = 0;
    end else if (m_busy) run++;
    else if (run > 0) begin
      if (len_q.size() == 0) chk("busy_len_unexpected", run, 32'd0);
      else chk("busy_len", run, len_q.pop_front());
      run = 0;
    end
    if (valid && ctl == 4'd7) begin
      if (rd_q.size() == 0) chk("read_unexpected", m_out, 32'hxxxxxxxx);
      else chk(dsel ? "mfhi" : "mflo", m_out, rd_q.pop_front());
    end
    if (valid && ctl >= 4'd1 && ctl <= 4'd4) begin
      if (st_q.size() == 0) chk("start_unexpected", {31'b0, m_start}, 32'hxxxxxxxx);
      else chk("start", {31'b0, m_start}, {31'b0, st_q.pop_front()});
    end
  end

  // Drives one cycle of stimulus and advances the reference model of committed/pending HI/LO
  task automatic step(input logic [3:0] op, input logic ds, input logic [31:0] a, input logic [31:0] b, input logic v);
    bit bsy;
    int n, sa, sbv;
    longint p;
    logic [63:0] up;
    logic [31:0] rh, rl;
    ctl = op; dsel = ds; va = a; vb = b; valid = v;
    bsy = cyc < free_at;
    sa = a; sbv = b;
    if (!rst_n) begin
      if (v && op == 4'd7) rd_q.push_back(32'd0);
      if (v && op >= 4'd1 && op <= 4'd4) st_q.push_back(1'b0);
    end else if (v) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        st_q.push_back(!bsy);
        if (!bsy) begin
          rh = n_hi; rl = n_lo;
          if (op == 4'd1) begin
            p = longint'(sa) * longint'(sbv);
            rh = p[63:32]; rl = p[31:0];
          end else if (op == 4'd2) begin
            up = 64'(a) * 64'(b);
            rh = up[63:32]; rl = up[31:0];
          end else if (b != 0 && op == 4'd3) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
              rl = 32'h80000000; rh = 0;
            end else begin
              rl = sa / sbv; rh = sa % sbv;
            end
          end else if (b != 0) begin
            rl = a / b; rh = a % b;
          end
          n = (op <= 4'd2) ? (sel ? 1 : 5) : (sel ? 3 : 10);
          o_hi = n_hi; o_lo = n_lo;
          n_hi = rh; n_lo = rl;
          free_at = cyc + n + 1;
          len_q.push_back(n);
        end
      end else if (op == 4'd5 && !bsy) begin
        n_lo = a; o_lo = a;
      end else if (op == 4'd6 && !bsy) begin
        n_hi = a; o_hi = a;
      end else if (op == 4'd7)
        rd_q.push_back(bsy ? (ds ? o_hi : o_lo) : (ds ? n_hi : n_lo));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    while (cyc < free_at) step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rd2();
    step(4'd7, 1'b0, 32'd0, 32'd0, 1'b1);
    step(4'd7, 1'b1, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    o_hi = 0; o_lo = 0; n_hi = 0; n_lo = 0;
    free_at = cyc;
    len_q.delete();
    step(4'd7, 1'b0, 32'd0, 32'd0, 1'b1);
    step(4'd1, 1'b0, 32'd3, 32'd3, 1'b1);
    step(4'd7, 1'b1, 32'd0, 32'd0, 1'b1);
    rst_n = 1;
  endtask

  task automatic rand_ops(input int iters);
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < iters; i++) begin
      op = 4'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        default: ;
      endcase
      step(op, 1'b0, a, b, 1'b1);
      if ($urandom_range(0, 1) == 1) step(4'($urandom_range(1, 6)), 1'b0, $urandom, $urandom, 1'b1);
      idle();
      rd2();
    end
  endtask

  initial begin
    #1 rst_n = 0;
    @(posedge clk);
    #1;
    do_reset();
    rd2();
    step(4'd1, 1'b0, 32'h7FFFFFFF, 32'd2, 1'b1); idle(); rd2();
    step(4'd1, 1'b0, 32'hFFFFFFFD, 32'd4, 1'b1); idle(); rd2();
    step(4'd2, 1'b0, 32'hFFFFFFFD, 32'd4, 1'b1); idle(); rd2();
    step(4'd3, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b1); idle(); rd2();
    step(4'd4, 1'b0, 32'd7, 32'd0, 1'b1); idle(); rd2();
    step(4'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1); idle(); rd2();
    step(4'd5, 1'b0, 32'h1234, 32'd0, 1'b1);
    step(4'd1, 1'b0, 32'd3, 32'd3, 1'b1);
    step(4'd6, 1'b0, 32'hDEAD, 32'd0, 1'b1);
    step(4'd1, 1'b0, 32'd5, 32'd5, 1'b1);
    rd2();
    idle(); rd2();
    step(4'd3, 1'b0, 32'd100, 32'd7, 1'b1);
    step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    do_reset();
    rd2();
    step(4'd1, 1'b0, 32'd6, 32'd7, 1'b1); idle(); rd2();
    rand_ops(40);
    sel = 1;
    do_reset();
    step(4'd1, 1'b0, 32'd3, 32'd4, 1'b1); idle();
    step(4'd1, 1'b0, 32'd5, 32'd6, 1'b1); idle(); rd2();
    step(4'd3, 1'b0, 32'd100, 32'd7, 1'b1); idle();
    step(4'd4, 1'b0, 32'd100, 32'd9, 1'b1); idle(); rd2();
    rand_ops(15);
    step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("reads_pending", rd_q.size(), 32'd0);
    chk("starts_pending", st_q.size(), 32'd0);
    chk("busy_runs_pending", len_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
